// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell iterated LSB first over WIDTH cycles,
// producing sum, carry-out and two's-complement overflow with a done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             last_bit;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] acc_shift;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

    // Full-adder cell and result shift; new bit enters at the MSB so that
    // after WIDTH shifts the first computed bit lands at bit 0.
    always_comb begin
        last_bit  = (cnt_q == CW'(WIDTH - 1));
        s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_next    = (a_sh_q[0] & b_sh_q[0]) | (c_q & (a_sh_q[0] ^ b_sh_q[0]));
        acc_shift = (acc_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    end

    // Datapath next-state
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    c_d    = cin;
                    cnt_d  = '0;
                    acc_d  = '0;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = acc_shift;
                c_d    = c_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    // c_q here is the carry into the MSB
                    sum_d  = acc_shift;
                    cout_d = c_next;
                    ovf_d  = c_q ^ c_next;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 16 against an
// arithmetic reference model of a+b+cin.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, start1, start16;
    logic [31:0] a_r, b_r;
    logic        cin_r;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy1, done1, cout1, ovf1;
    logic [0:0]  sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int          sel = 8;
    logic        cur_busy, cur_done, cur_cout, cur_ovf;
    logic [31:0] cur_sum;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a_r[7:0]), .b(b_r[7:0]),
        .cin(cin_r), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a_r[0:0]), .b(b_r[0:0]),
        .cin(cin_r), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );
    serial_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a_r[15:0]), .b(b_r[15:0]),
        .cin(cin_r), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    always_comb begin
        cur_busy = busy8;
        cur_done = done8;
        cur_cout = cout8;
        cur_ovf  = ovf8;
        cur_sum  = {24'd0, sum8};
        case (sel)
            1: begin
                cur_busy = busy1; cur_done = done1; cur_cout = cout1;
                cur_ovf = ovf1; cur_sum = {31'd0, sum1};
            end
            16: begin
                cur_busy = busy16; cur_done = done16; cur_cout = cout16;
                cur_ovf = ovf16; cur_sum = {16'd0, sum16};
            end
            default: ;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum for sum/cout, signed range test for overflow
    task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                         output logic [31:0] s, output logic co, output logic ov);
        longint mask, ua, ub, full, sa, sb, tot, half;
        mask = (64'sd1 <<< w) - 1;
        half = 64'sd1 <<< (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        full = ua + ub + longint'(cv);
        s    = 32'(full & mask);
        co   = ((full >>> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (mask + 1) : ua;
        sb   = (ub >= half) ? ub - (mask + 1) : ub;
        tot  = sa + sb + longint'(cv);
        ov   = (tot > half - 1) || (tot < -half);
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start1 = v;
            16:      start16 = v;
            default: start8 = v;
        endcase
    endtask

    // Drives operands with start high across one rising edge; returns at the
    // following falling edge with start still asserted.
    task automatic launch(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        @(negedge clk);
        sel   = w;
        a_r   = av;
        b_r   = bv;
        cin_r = cv;
        set_start(w, 1'b1);
        @(negedge clk);
    endtask

    // Called at the first falling edge after the accepting edge.
    task automatic finish_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                             input string tag);
        int j;
        logic [31:0] es;
        logic eco, eov;
        j = 1;
        check_val({tag, ".busy"}, 32'(cur_busy), 32'd1);
        while (!cur_done && j < w + 4) begin
            @(negedge clk);
            j++;
            if (!cur_done && j <= w) check_val({tag, ".busyrun"}, 32'(cur_busy), 32'd1);
        end
        check_val({tag, ".lat"}, 32'(j - 1), 32'(w));
        model(w, av, bv, cv, es, eco, eov);
        check_val({tag, ".sum"}, cur_sum, es);
        check_val({tag, ".cout"}, 32'(cur_cout), 32'(eco));
        check_val({tag, ".ovf"}, 32'(cur_ovf), 32'(eov));
        @(negedge clk);
        check_val({tag, ".pulse"}, 32'(cur_done), 32'd0);
        check_val({tag, ".idle"}, 32'(cur_busy), 32'd0);
        check_val({tag, ".hold"}, cur_sum, es);
    endtask

    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input string tag);
        launch(w, av, bv, cv);
        set_start(w, 1'b0);
        a_r   = $urandom;
        b_r   = $urandom;
        cin_r = 1'($urandom);
        finish_op(w, av, bv, cv, tag);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start8 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        a_r = '0; b_r = '0; cin_r = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.busy", 32'(busy8), 32'd0);
        check_val("rst.done", 32'(done8), 32'd0);
        check_val("rst.sum", 32'(sum8), 32'd0);
        check_val("rst.cout", 32'(cout8), 32'd0);
        check_val("rst.ovf", 32'(ovf8), 32'd0);
        check_val("rst.busy1", 32'(busy1), 32'd0);
        check_val("rst.busy16", 32'(busy16), 32'd0);
        rst_n = 1'b1;

        run_op(8, 32'h3C, 32'h05, 1'b0, "basic");
        run_op(8, 32'hFF, 32'h01, 1'b0, "wrap");
        run_op(8, 32'h00, 32'h00, 1'b1, "cin");
        run_op(8, 32'h7F, 32'h01, 1'b0, "ovfpos");
        run_op(8, 32'h80, 32'h80, 1'b0, "ovfneg");

        // start held high and operand changed mid-run: only the latched values count
        launch(8, 32'h10, 32'h20, 1'b0);
        a_r = 32'hAA;
        finish_op(8, 32'h10, 32'h20, 1'b0, "ign");
        @(negedge clk);
        set_start(8, 1'b0);
        finish_op(8, 32'hAA, 32'h20, 1'b0, "ign2");

        // Reset asserted for the 4th RUN edge
        launch(8, 32'h55, 32'h55, 1'b0);
        set_start(8, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mrst.busy", 32'(busy8), 32'd0);
        check_val("mrst.done", 32'(done8), 32'd0);
        check_val("mrst.sum", 32'(sum8), 32'd0);
        check_val("mrst.cout", 32'(cout8), 32'd0);
        check_val("mrst.ovf", 32'(ovf8), 32'd0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check_val("mrst.nodone", 32'(dones), 32'd0);
        run_op(8, 32'h01, 32'h02, 1'b0, "fresh");

        for (int i = 0; i < 20; i++) run_op(8, $urandom, $urandom, 1'($urandom), "rnd8");
        for (int i = 0; i < 16; i++) run_op(1, $urandom, $urandom, 1'($urandom), "rnd1");
        for (int i = 0; i < 20; i++) run_op(16, $urandom, $urandom, 1'($urandom), "rnd16");
        run_op(16, 32'hFFFF, 32'h0000, 1'b1, "w16wrap");
        run_op(16, 32'h7FFF, 32'h7FFF, 1'b1, "w16ovf");
        run_op(1, 32'h1, 32'h1, 1'b1, "w1all");
        run_op(1, 32'h0, 32'h0, 1'b1, "w1cin");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
